// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, feeder state encoding and burst request record
// for the SDRAM write-side feeder slice.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 21;
  localparam int unsigned SDRAM_DATA_W = 32;
  localparam int unsigned SDRAM_COL_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_UPDATE
  } feeder_state_t;

  typedef struct packed {
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [7:0]              len;
  } burst_req_t;

endpackage

// File: rtl/sdram_wr_feeder_if.sv
// sdram_wr_feeder_if: user word stream plus write-engine burst handshake.
//   i_data_valid/i_data/o_data_ready : user stream into the feeder FIFO
//   o_wr_en/o_wr_addr/o_burst_len    : burst request to the write engine
//   o_wr_data                        : write data, valid the cycle after each ack
//   i_wr_ack/i_wr_end                : engine data-consume and burst-complete
// Modports: slave = the feeder, master = the driving side (user + engine).
interface sdram_wr_feeder_if;
  import sdram_pkg::*;

  logic                    i_data_valid;
  logic [SDRAM_DATA_W-1:0] i_data;
  logic                    o_data_ready;
  logic                    o_wr_en;
  logic [SDRAM_ADDR_W-1:0] o_wr_addr;
  logic [7:0]              o_burst_len;
  logic [SDRAM_DATA_W-1:0] o_wr_data;
  logic                    i_wr_ack;
  logic                    i_wr_end;

  modport slave (
    input  i_data_valid, i_data, i_wr_ack, i_wr_end,
    output o_data_ready, o_wr_en, o_wr_addr, o_burst_len, o_wr_data
  );

  modport master (
    output i_data_valid, i_data, i_wr_ack, i_wr_end,
    input  o_data_ready, o_wr_en, o_wr_addr, o_burst_len, o_wr_data
  );

endinterface

// File: rtl/sdram_sync_fifo.sv
// sdram_sync_fifo: single-clock FIFO with a registered read port.
//   push/din  : write; accepted when not full, or when full with a same-cycle pop
//   pop/dout  : dout loads the head word on the edge at which pop is sampled
//   count     : occupancy, 0..2**AW
// Synchronous active-high reset empties the FIFO and clears dout.
module sdram_sync_fifo #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) begin
        rp   <= rp + 1'b1;
        dout <= mem[rp];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_wr_feeder.sv
// sdram_wr_feeder: buffers 32-bit user words and carves them into row-bounded
// bursts for the SDRAM write-burst engine. Linear word addressing from a
// loadable base, wrapping at the top of the 21-bit space.
//   clk, rst         : clock, synchronous active-high reset
//   i_base_load/addr : load write pointer (honoured in IDLE only)
//   i_flush          : level, issue any partial burst
//   bus (slave)      : user stream + engine request/data/ack/end
//   o_fifo_count     : FIFO occupancy
//   o_busy           : FSM not in IDLE
// Optional: define SDRAM_WR_FEEDER_TIMEOUT_EN to flush a partial burst after
// TIMEOUT idle cycles.
module sdram_wr_feeder
  import sdram_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 9,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_base_load,
  input  logic [SDRAM_ADDR_W-1:0] i_base_addr,
  input  logic                    i_flush,
  sdram_wr_feeder_if.slave        bus,
  output logic [FIFO_AW:0]        o_fifo_count,
  output logic                    o_busy
);

  if (BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT < 2) begin : g_bad_param
    $error("sdram_wr_feeder: BURST_LEN must be 1..255 and TIMEOUT >= 2");
  end

  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]      BL    = 16'(BURST_LEN);

  feeder_state_t           state, state_d;
  burst_req_t              req;
  logic [SDRAM_ADDR_W-1:0] wr_ptr;
  logic [7:0]              popped;
  logic [FIFO_AW:0]        count;
  logic [SDRAM_DATA_W-1:0] rd_data;
  logic                    full, push, pop, issue, timeout_hit;
  logic [15:0]             cnt_w, room_w, len_w;
  logic [7:0]              len_d;

  assign full   = (count == DEPTH);
  assign push   = bus.i_data_valid && !full;
  assign pop    = (state == ST_XFER) && bus.i_wr_ack && (popped < req.len);
  assign cnt_w  = 16'(count);
  assign room_w = 16'd256 - 16'(wr_ptr[SDRAM_COL_W-1:0]);
  assign issue  = (count != '0) && ((cnt_w >= BL) || i_flush || timeout_hit);

  always_comb begin
    len_w = cnt_w;
    if (BL < len_w)     len_w = BL;
    if (room_w < len_w) len_w = room_w;
    len_d = len_w[7:0];
  end

  sdram_sync_fifo #(
    .AW (FIFO_AW),
    .DW (SDRAM_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.i_data),
    .pop   (pop),
    .dout  (rd_data),
    .count (count)
  );

`ifdef SDRAM_WR_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] idle_cnt;
  logic          idle_run;

  assign idle_run    = (state == ST_IDLE) && (count != '0) && (cnt_w < BL) && !i_flush;
  assign timeout_hit = (idle_cnt >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || push || (state == ST_IDLE && state_d == ST_REQ)) idle_cnt <= '0;
    else if (idle_run && !timeout_hit)                           idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (!i_base_load && issue) state_d = ST_REQ;
      ST_REQ:    state_d = ST_XFER;
      ST_XFER:   if (bus.i_wr_end) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pointer advances by words actually popped, so an early i_wr_end leaves
  // the remainder queued for the next burst at the right address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      req    <= '0;
      wr_ptr <= '0;
      popped <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          popped <= '0;
          if (i_base_load) wr_ptr <= i_base_addr;
          else if (issue)  req    <= '{addr: wr_ptr, len: len_d};
        end
        ST_XFER:   if (pop) popped <= popped + 8'd1;
        ST_UPDATE: wr_ptr <= wr_ptr + SDRAM_ADDR_W'(popped);
        default: ;
      endcase
    end
  end

  assign bus.o_data_ready = !full;
  assign bus.o_wr_en      = (state == ST_REQ);
  assign bus.o_wr_addr    = req.addr;
  assign bus.o_burst_len  = req.len;
  assign bus.o_wr_data    = rd_data;
  assign o_fifo_count     = count;
  assign o_busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// tb_sdram_wr_feeder: directed bench for sdram_wr_feeder. A negedge monitor
// captures every burst request; an engine task acks words and checks data.
module tb_sdram_wr_feeder;
  import sdram_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned BL = 64;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        base_load = 1'b0;
  logic [20:0] base_addr = '0;
  logic        flush = 1'b0;
  logic [AW:0] fifo_count;
  logic        busy;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] exp_q[$];
  burst_req_t  bq[$];

  always #5 clk = ~clk;

  sdram_wr_feeder_if bus ();

  sdram_wr_feeder #(
    .FIFO_AW   (AW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_base_load  (base_load),
    .i_base_addr  (base_addr),
    .i_flush      (flush),
    .bus          (bus),
    .o_fifo_count (fifo_count),
    .o_busy       (busy)
  );

  always @(negedge clk)
    if (!rst && bus.o_wr_en) bq.push_back('{addr: bus.o_wr_addr, len: bus.o_burst_len});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_words(input logic [31:0] start, input int n, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.i_data_valid = 1'b1;
      bus.i_data       = start + 32'(i);
      @(negedge clk);
      if (bus.o_data_ready) begin
        exp_q.push_back(bus.i_data);
        acc++;
      end
    end
    @(posedge clk); #1;
    bus.i_data_valid = 1'b0;
  endtask

  task automatic get_burst(output burst_req_t b);
    int n = 0;
    while (bq.size() == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (bq.size() == 0) begin
      check("burst_timeout", 32'd0, 32'd1);
      b = '0;
    end else begin
      b = bq.pop_front();
    end
  endtask

  task automatic serve(input logic [20:0] ea, input int el, input int extra);
    burst_req_t  b;
    logic [31:0] e, last;
    last = '0;
    get_burst(b);
    check("burst_addr", 32'(b.addr), 32'(ea));
    check("burst_len", 32'(b.len), 32'(el));
    @(posedge clk); #1;
    bus.i_wr_ack = 1'b1;
    for (int i = 0; i < el + extra; i++) begin
      @(posedge clk); #1;
      if (i == el + extra - 1) bus.i_wr_ack = 1'b0;
      @(negedge clk);
      if (i < el) e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      else        e = last;
      check("wr_data", bus.o_wr_data, e);
      last = e;
    end
    @(posedge clk); #1;
    bus.i_wr_end = 1'b1;
    @(posedge clk); #1;
    bus.i_wr_end = 1'b0;
  endtask

  task automatic idle_gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic load_base(input logic [20:0] a);
    @(posedge clk); #1;
    base_load = 1'b1;
    base_addr = a;
    @(posedge clk); #1;
    base_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},  32'(bus.o_wr_en), 32'd0);
    check({tag, "_addr"},   32'(bus.o_wr_addr), 32'd0);
    check({tag, "_len"},    32'(bus.o_burst_len), 32'd0);
    check({tag, "_data"},   bus.o_wr_data, 32'd0);
    check({tag, "_ready"},  32'(bus.o_data_ready), 32'd1);
    check({tag, "_count"},  32'(fifo_count), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [20:0] addr;
    int          len;
  } exp_burst_t;

  exp_burst_t fill_tab[8] = '{
    '{21'h000130, 64}, '{21'h000170, 64}, '{21'h0001B0, 64}, '{21'h0001F0, 16},
    '{21'h000200, 64}, '{21'h000240, 64}, '{21'h000280, 64}, '{21'h0002C0, 64}
  };

  initial begin
    int         acc;
    burst_req_t b;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_wr_ack     = 1'b0;
    bus.i_wr_end     = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // One full burst from base 0.
    push_words(32'h100, 64, acc);
    serve(21'h000000, 64, 0);
    idle_gap();
    check("t1_count", 32'(fifo_count), 32'd0);

    // Partial burst by flush; pointer continues at 0x40; extra acks hold data.
    push_words(32'h200, 10, acc);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t3_count", 32'(fifo_count), 32'd10);
    check("t3_busy", 32'(busy), 32'd0);
    pulse_flush();
    serve(21'h000040, 10, 2);
    idle_gap();

    // Row split: 16 words to end of row, 48 after flush.
    load_base(21'h0000F0);
    push_words(32'h300, 64, acc);
    serve(21'h0000F0, 16, 0);
    idle_gap();
    check("t4_count", 32'(fifo_count), 32'd48);
    pulse_flush();
    serve(21'h000100, 48, 0);
    idle_gap();

    // Fill to depth with engine stalled, then drain in order.
    push_words(32'h1000, 513, acc);
    @(negedge clk);
    check("fill_accepted", 32'(acc), 32'd512);
    check("fill_ready", 32'(bus.o_data_ready), 32'd0);
    check("fill_count", 32'(fifo_count), 32'd512);
    check("fill_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) serve(fill_tab[i].addr, fill_tab[i].len, 0);
    idle_gap();
    check("fill_rem", 32'(fifo_count), 32'd48);
    pulse_flush();
    serve(21'h000300, 48, 0);
    idle_gap();

    // Address wrap at top of space.
    load_base(21'h1FFFC0);
    push_words(32'h4000, 128, acc);
    serve(21'h1FFFC0, 64, 0);
    serve(21'h000000, 64, 0);
    idle_gap();

    // Reset during XFER.
    push_words(32'h5000, 64, acc);
    get_burst(b);
    check("t7_addr", 32'(b.addr), 32'h40);
    check("t7_len", 32'(b.len), 32'd64);
    @(posedge clk); #1;
    bus.i_wr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) bus.i_wr_ack = 1'b0;
      @(negedge clk);
      check("t7_data", bus.o_wr_data, 32'h5000 + 32'(i));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    bq.delete();
    push_words(32'h6000, 5, acc);
    pulse_flush();
    serve(21'h000000, 5, 0);
    idle_gap();

`ifdef SDRAM_WR_FEEDER_TIMEOUT_EN
    begin
      int n = 0;
      push_words(32'h7000, 10, acc);
      while (bq.size() == 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("timeout_window", 32'(n >= int'(TO) - 4 && n <= int'(TO) + 4), 32'd1);
      serve(21'h000005, 10, 0);
      idle_gap();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
